dmem_responder: RTL and testbench

- Target-side data memory that services load/store requests from the memory-access stage over a valid/ready request/response handshake.
- Owns a byte-addressed data array and performs byte-lane merging on stores and sign/zero extension on loads.
- Adds a configurable access latency.
- Flags misaligned and out-of-range requests without touching memory.

---
 rtl/dmem_responder_if.sv | 35 +++
 rtl/dmem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the memory-access stage (master) and the
// data memory responder (slave).
//   req_valid_i / req_ready_o : request handshake
//   req_we_i                  : 1 = store, 0 = load
//   req_funct_i[2:0]          : RISC-V funct3 access type, [9:3] unused
//   req_addr_i / req_wdata_i  : byte address / store data
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_rdata_o / rsp_err_o   : extended load data / error flag
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [9:0]  req_funct_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_funct_i, req_addr_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Byte-addressed data memory answering one load/store at a time with a fixed
// access latency. Stores merge byte lanes (little-endian); loads are sign- or
// zero-extended. Misaligned, out-of-range and illegal accesses return
// rsp_err_o = 1 with zero data and leave the array untouched.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-high (array contents are kept)
//   bus   : dmem_responder_if.slave request/response bundle
// Parameters:
//   DEPTH   : array size in bytes
//   LATENCY : wait cycles between acceptance and response (0..15)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  // Latched request
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [7:0]  r_mem [DEPTH];

  logic [2:0]    w_size;
  logic [32:0]   w_last;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_illegal;
  logic          w_err;
  logic          w_wr_en;
  logic          w_access;
  logic [AW-1:0] w_idx  [4];
  logic [7:0]    w_byte [4];
  logic [31:0]   w_load_data;
  logic          w_unused_funct;

  // funct[9:3] carries no meaning for this block
  assign w_unused_funct = ^bus.req_funct_i[9:3];

  // ---------------------------------------------------------------------------
  // Decode of the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    w_size = 3'd1;
    case (r_funct3)
      F_H, F_HU: w_size = 3'd2;
      F_W:       w_size = 3'd4;
      default:   w_size = 3'd1;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign w_last = {1'b0, r_addr} + 33'(w_size) - 33'd1;

  always_comb begin
    w_misaligned = 1'b0;
    if (r_funct3 == F_W && r_addr[1:0] != 2'b00) begin
      w_misaligned = 1'b1;
    end
    if ((r_funct3 == F_H || r_funct3 == F_HU) && r_addr[0]) begin
      w_misaligned = 1'b1;
    end
  end

  assign w_out_of_range = (w_last >= 33'(DEPTH));

  always_comb begin
    w_illegal = 1'b0;
    if (r_funct3 == 3'b011 || r_funct3 == 3'b110 || r_funct3 == 3'b111) begin
      w_illegal = 1'b1;
    end
    if (r_we && (r_funct3 == F_BU || r_funct3 == F_HU)) begin
      w_illegal = 1'b1;
    end
  end

  assign w_err = w_misaligned | w_out_of_range | w_illegal;

  // ---------------------------------------------------------------------------
  // Byte lanes
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx[k]  = AW'(r_addr + k);
      w_byte[k] = r_mem[w_idx[k]];
    end
  end

  always_comb begin
    w_load_data = '0;
    case (r_funct3)
      F_B:  w_load_data = {{24{w_byte[0][7]}}, w_byte[0]};
      F_BU: w_load_data = {24'h000000, w_byte[0]};
      F_H:  w_load_data = {{16{w_byte[1][7]}}, w_byte[1], w_byte[0]};
      F_HU: w_load_data = {16'h0000, w_byte[1], w_byte[0]};
      F_W:  w_load_data = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
      default: w_load_data = '0;
    endcase
  end

  // The access happens on the edge that moves WAIT -> RESP
  assign w_access = (r_state == WAIT) && (r_cnt == '0);
  assign w_wr_en  = w_access && r_we && !w_err && !rst_i;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_idx[0]] <= r_wdata[7:0];
      if (w_size != 3'd1) begin
        r_mem[w_idx[1]] <= r_wdata[15:8];
      end
      if (w_size == 3'd4) begin
        r_mem[w_idx[2]] <= r_wdata[23:16];
        r_mem[w_idx[3]] <= r_wdata[31:24];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  // Every acceptance passes through WAIT with the counter loaded to LATENCY
  // and leaves at zero, so RESP is entered LATENCY+1 edges after acceptance;
  // LATENCY = 0 takes the same path with a single WAIT cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i && r_req_ready) begin
            r_we        <= bus.req_we_i;
            r_funct3    <= bus.req_funct_i[2:0];
            r_addr      <= bus.req_addr_i;
            r_wdata     <= bus.req_wdata_i;
            r_req_ready <= 1'b0;
            r_cnt       <= 4'(LATENCY);
            r_state     <= WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_err       <= w_err;
            r_rdata     <= (w_err || r_we) ? '0 : w_load_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference byte store
  logic [7:0] ref_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [2:0]  f;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: applies one access to ref_mem and returns the response
  task automatic model(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned sz;
    longint unsigned last;
    logic [31:0] v;
    case (f)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 1;
    endcase
    er = 1'b0;
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) er = 1'b1;
    if (we && (f == 3'd4 || f == 3'd5)) er = 1'b1;
    if ((a % sz) != 0) er = 1'b1;
    last = {32'h0, a} + longint'(sz) - 1;
    if (last >= longint'(DEPTH)) er = 1'b1;
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int unsigned k = 0; k < sz; k++) ref_mem[a + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int unsigned k = 0; k < sz; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
        if (f == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  // One full transaction; starts and ends at a falling edge
  task automatic xfer(input logic we, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, input int unsigned hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_funct_i = {7'($urandom), f};
    bus.req_addr_i  = a;
    bus.req_wdata_i = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    lat = 0;
    while (bus.rsp_valid_o !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata_o;
    er = bus.rsp_err_o;
    repeat (hold) @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic we, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] wd, input int unsigned hold,
                           input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic er;
    int lat;
    xfer(we, f, a, wd, hold, rd, er, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_latency"}, 32'(lat), 32'(LAT + 1));
  endtask

  initial begin
    logic [31:0] mrd;
    logic        mer;
    logic [31:0] a;
    logic        we;
    logic [2:0]  f;
    int          n;
    int unsigned sel;

    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_funct_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;

    // ---------------- reset state ----------------
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_rdata",     bus.rsp_rdata_o,      32'd0);
    check("rst_err",       32'(bus.rsp_err_o),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready_o), 32'd1);

    // ---------------- directed vector table ----------------
    //                we    f      addr           wdata          exp_rd         err
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0});
    vecs.push_back('{1'b0, 3'd5, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0011, 32'h0000_1234, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_03FF, 32'h0000_005A, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'h0000_03FF, 32'h0,         32'h0000_005A, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_03FC, 32'h0,         32'h5AFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_03FF, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_03FE, 32'h0,         32'h0000_5AFE, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_03FE, 32'h0,         32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 32'h0000_0000, 32'h1,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd4, 32'h0000_0020, 32'hFF,        32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_03FE, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFFC, 32'h7777_7777, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0020, 32'h0BAD_F00D, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd5, 32'h0000_0022, 32'h0,         32'h0000_0BAD, 1'b0});

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].f, vecs[i].addr, vecs[i].wdata, mrd, mer);
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].f, vecs[i].addr,
                vecs[i].wdata, 0, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // ---------------- held response, blocked second request ----------------
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_funct_i = {7'd0, 3'd2};
    bus.req_addr_i  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    // Keep a different request pending; it must wait for the handshake
    bus.req_funct_i = {7'd0, 3'd0};
    bus.req_addr_i  = 32'h13;
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_first_rdata", bus.rsp_rdata_o, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), 32'(bus.rsp_valid_o), 32'd1);
      check($sformatf("hold%0d_rdata", i), bus.rsp_rdata_o, 32'hDEAD_BEEF);
      check($sformatf("hold%0d_ready", i), 32'(bus.req_ready_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("hs_valid_drop", 32'(bus.rsp_valid_o), 32'd0);
    check("hs_ready_back", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("second_accepted", 32'(bus.req_ready_o), 32'd0);
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("second_rdata", bus.rsp_rdata_o, 32'hFFFF_FFDE);
    check("second_latency", 32'(n), 32'(LAT + 1));
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;

    // ---------------- reset during WAIT of a store ----------------
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_funct_i = {7'd0, 3'd2};
    bus.req_addr_i  = 32'h20;
    bus.req_wdata_i = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("midrst_rdata",     bus.rsp_rdata_o,      32'd0);
    check("midrst_err",       32'(bus.rsp_err_o),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_check("after_rst", 1'b0, 3'd2, 32'h20, 32'h0, 0, 32'h0BAD_F00D, 1'b0);

    // ---------------- randomized against the model ----------------
    for (int unsigned w = 0; w < 16; w++) begin
      a = 32'h100 + 4 * w;
      model(1'b1, 3'd2, a, $urandom, mrd, mer);
      run_check($sformatf("pre%0d", w), 1'b1, 3'd2, a,
                {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]}, 0, mrd, mer);
    end

    for (int i = 0; i < 250; i++) begin
      logic [31:0] wd;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'h100 + $urandom_range(0, 63);
      else if (sel == 8) a = 32'h3FC + $urandom_range(0, 7);
      else               a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      we = ($urandom_range(0, 2) == 0);
      f  = 3'($urandom_range(0, 7));
      wd = $urandom;
      model(we, f, a, wd, mrd, mer);
      run_check($sformatf("rnd%0d", i), we, f, a, wd, $urandom_range(0, 2), mrd, mer);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
